sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/cpu_arb_pkg.sv | 15 +
 rtl/arb_prio_sel.sv | 56 +++++
 rtl/sram_port_arbiter.sv | 86 ++++++++
 tb/tb_sram_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the CPU-side SRAM port arbiter: the owner encoding
// of an issued access and the default starvation limit.
package cpu_arb_pkg;

  // Who issued the access whose response arrives next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } owner_e;

  // Consecutive data grants tolerated while an instruction request waits.
  localparam int STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/arb_prio_sel.sv
// Grant decision between the instruction and data ports: data wins by
// default, but inst is forced through once it has waited STARVE_MAX grants.
module arb_prio_sel
  import cpu_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  // A limit of 0 still needs a one-bit counter to stay legal.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX);

  // Grant selection and next starvation count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    grant_inst     = 1'b0;
    grant_data     = 1'b0;
    starve_cnt_nxt = starve_cnt;
    if (!rst) begin
      grant_inst = inst_req & (~data_req | starved);
      grant_data = data_req & ~grant_inst;
    end
    // The count only tracks an inst request that keeps losing to data.
    if (!inst_req || grant_inst) begin
      starve_cnt_nxt = '0;
    end else if (grant_data && !starved) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-cycle-latency SRAM between an instruction port and a
// data port. The grant is issued combinationally; the response is routed
// back one cycle later to whichever port owned the access.
module sram_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  logic   grant_inst;
  logic   grant_data;
  owner_e owner_q;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  assign sram_en      = grant_inst | grant_data;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // Steer the granted requester onto the SRAM command; zero when idle.
  always_comb begin
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_inst) begin
      sram_wen   = inst_wen;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (grant_data) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  // Remember who owns the access whose response appears next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_NONE;
    end else if (grant_inst) begin
      owner_q <= OWNER_INST;
    end else if (grant_data) begin
      owner_q <= OWNER_DATA;
    end else begin
      owner_q <= OWNER_NONE;
    end
  end

  // Gating with rst drops the response of an access issued just before reset.
  assign inst_data_ok = ~rst & (owner_q == OWNER_INST);
  assign data_data_ok = ~rst & (owner_q == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = data_data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: waiting cycles of inst, and owner of last cycle's access.
  int m_wait  = 0;
  int m_owner = 0;  // 0 none, 1 inst, 2 data

  logic [7:0] grant_hist;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wen     (inst_wen),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle_inputs();
    inst_req = 0; data_req = 0;
    inst_wen = '0; data_wen = '0;
    inst_addr = '0; data_addr = '0;
    inst_wdata = '0; data_wdata = '0;
  endtask

  task automatic set_random_inputs();
    inst_req   = $urandom_range(0, 1);
    data_req   = $urandom_range(0, 1);
    inst_wen   = 4'($urandom);
    data_wen   = 4'($urandom);
    inst_addr  = $urandom;
    data_addr  = $urandom;
    inst_wdata = $urandom;
    data_wdata = $urandom;
    sram_rdata = $urandom;
  endtask

  // Called at a negedge with inputs driven: check outputs, advance one cycle.
  task automatic tick();
    bit pick_inst, pick_data;
    #1;
    pick_inst = 0;
    pick_data = 0;
    if (!rst) begin
      if (inst_req && !data_req) pick_inst = 1;
      else if (data_req && !inst_req) pick_data = 1;
      else if (inst_req && data_req) begin
        if (m_wait >= STARVE_MAX) pick_inst = 1;
        else pick_data = 1;
      end
    end
    check("sram_en",      32'(sram_en),      32'(pick_inst | pick_data));
    check("inst_addr_ok", 32'(inst_addr_ok), 32'(pick_inst));
    check("data_addr_ok", 32'(data_addr_ok), 32'(pick_data));
    check("sram_wen",   32'(sram_wen),
          pick_inst ? 32'(inst_wen)  : pick_data ? 32'(data_wen)  : 32'd0);
    check("sram_addr",  sram_addr,
          pick_inst ? inst_addr  : pick_data ? data_addr  : 32'd0);
    check("sram_wdata", sram_wdata,
          pick_inst ? inst_wdata : pick_data ? data_wdata : 32'd0);
    check("inst_data_ok", 32'(inst_data_ok), 32'(!rst && m_owner == 1));
    check("data_data_ok", 32'(data_data_ok), 32'(!rst && m_owner == 2));
    check("inst_rdata", inst_rdata, (!rst && m_owner == 1) ? sram_rdata : 32'd0);
    check("data_rdata", data_rdata, (!rst && m_owner == 2) ? sram_rdata : 32'd0);
    grant_hist = {grant_hist[6:0], inst_addr_ok};
    @(posedge clk);
    if (rst) begin
      m_wait  = 0;
      m_owner = 0;
    end else begin
      m_owner = pick_inst ? 1 : pick_data ? 2 : 0;
      if (!inst_req || pick_inst) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait++;
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle_inputs();
    sram_rdata = '0;
    rst = 1;
    @(negedge clk);
    // Reset state with requests asserted: nothing may be accepted.
    inst_req = 1; data_req = 1;
    tick();
    tick();
    rst = 0;
    set_idle_inputs();

    // Single data read; first grant right after reset.
    data_req = 1; data_addr = 32'h100;
    tick();
    data_req = 0; data_addr = '0; sram_rdata = 32'hDEADBEEF;
    #1;
    check("dread_ok",    32'(data_data_ok), 32'd1);
    check("dread_rdata", data_rdata,        32'hDEADBEEF);
    tick();

    // Continuous contention: expect D,D,D,I,D,D,D,I.
    grant_hist = '0;
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 8; i++) begin
      sram_rdata = $urandom;
      tick();
    end
    check("contention_pattern", 32'(grant_hist), 32'h11);

    // Idle clears the starvation count: contention restarts at D,D,D,I.
    inst_req = 1; data_req = 1;
    tick();
    tick();
    set_idle_inputs();
    tick();
    grant_hist = '0;
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 4; i++) tick();
    check("idle_clears_cnt", 32'(grant_hist[3:0]), 32'h1);
    set_idle_inputs();
    tick();

    // Inst write followed by a data read.
    inst_req = 1; inst_wen = 4'hF; inst_addr = 32'h40; inst_wdata = 32'h12345678;
    #1;
    check("iwrite_wen", 32'(sram_wen), 32'hF);
    tick();
    set_idle_inputs();
    data_req = 1; data_addr = 32'h200;
    #1;
    check("iwrite_then_dread", {30'd0, inst_data_ok, data_addr_ok}, 32'h3);
    tick();
    set_idle_inputs();
    tick();

    // Reset mid-transfer with a partially built starvation count.
    inst_req = 1; data_req = 1;
    tick();
    tick();
    rst = 1;
    #1;
    check("rst_drops_resp", {30'd0, inst_data_ok, data_data_ok}, 32'h0);
    tick();
    rst = 0;
    grant_hist = '0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_clears_cnt", 32'(grant_hist[3:0]), 32'h1);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      set_random_inputs();
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;
    set_idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
